// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Requester indices, as stored in the grant register
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Memory direction encodings
    localparam logic DRW_READ  = 1'b0;
    localparam logic DRW_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter producing a one-hot grant.
// With RR set, ties go to the port that did not win last time;
// otherwise the data port always wins a tie.
module rr_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic lastGrant;

    // Remember who won the most recent accepted grant; starts at the data
    // port so the fetch port takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lastGrant <= PORT_D;
        end else if (advance) begin
            lastGrant <= grant[1];
        end
    end

    // Resolve the current requests into a one-hot grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            if ((RR != 0) && (lastGrant == PORT_D)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory handshake between the fetch port (0) and the data
// port (1): grants one request, issues a start pulse, waits for the
// memory done strobe under a timeout and returns data with a done pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RR      = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        idone,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        ddone,
    output logic        err,
    output logic        AXIStart,
    output logic        DRW,
    output logic [31:0] addressM,
    output logic [31:0] writeDataM,
    input  logic [31:0] readDataM,
    input  logic        doneM
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state;
    state_t        stateNext;
    logic [1:0]    grant;
    logic          advance;
    logic          grantIdx;
    logic [CW-1:0] waitCount;
    logic          timedOut;
    logic          finish;
    logic          respErr;
    logic [31:0]   respData;

    rr_arbiter2 #(
        .RR(RR)
    ) arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    ({dreq, ireq}),
        .advance(advance),
        .grant  (grant)
    );

    assign advance  = (state == IDLE) && (grant != 2'b00);
    assign timedOut = (TIMEOUT != 0) && (waitCount == CW'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state selection; doneM only matters while issuing or waiting
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (advance) stateNext = ISSUE;
            ISSUE:   stateNext = doneM ? RESP : WAIT;
            WAIT:    if (doneM || timedOut) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Completion decode: a memory done always beats a simultaneous timeout
    always_comb begin
        finish   = ((state == ISSUE) && doneM) ||
                   ((state == WAIT) && (doneM || timedOut));
        respErr  = finish && !doneM;
        respData = doneM ? readDataM : 32'h0;
    end

    // Wait counter: cleared when a grant is taken, saturates while waiting
    always_ff @(posedge clk) begin
        if (!reset) begin
            waitCount <= '0;
        end else if (advance) begin
            waitCount <= '0;
        end else if ((state == WAIT) && (waitCount != '1)) begin
            waitCount <= waitCount + 1'b1;
        end
    end

    // Registered outputs: transaction latch on grant, pulses and read data
    // on completion; read data per port holds until that port completes again
    always_ff @(posedge clk) begin
        if (!reset) begin
            grantIdx   <= PORT_I;
            AXIStart   <= 1'b0;
            DRW        <= DRW_READ;
            addressM   <= 32'h0;
            writeDataM <= 32'h0;
            idone      <= 1'b0;
            ddone      <= 1'b0;
            err        <= 1'b0;
            irdata     <= 32'h0;
            drdata     <= 32'h0;
        end else begin
            AXIStart <= advance;
            idone    <= finish && (grantIdx == PORT_I);
            ddone    <= finish && (grantIdx == PORT_D);
            err      <= respErr;
            if (advance) begin
                grantIdx   <= grant[1];
                addressM   <= grant[1] ? daddr : iaddr;
                writeDataM <= grant[1] ? dwdata : 32'h0;
                DRW        <= (grant[1] && dwrite) ? DRW_WRITE : DRW_READ;
            end
            if (finish && (grantIdx == PORT_I)) begin
                irdata <= respData;
            end
            if (finish && (grantIdx == PORT_D)) begin
                drdata <= respData;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin unit and a fixed-priority unit share
// all inputs; a transaction-level model predicts winners, timing and data.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwrite, doneM;
    logic [31:0] iaddr, daddr, dwdata, readDataM;

    logic [31:0] irdata[2], drdata[2], addressM[2], writeDataM[2];
    logic        idone[2], ddone[2], err[2], axiStart[2], drw[2];

    int checks   = 0;
    int failures = 0;

    // Model state: last winner per unit and held read data per port
    bit          lastPort[2];
    logic [31:0] modelI[2];
    logic [31:0] modelD[2];

    always #5 clk = ~clk;

    mem_arbiter #(.RR(1), .TIMEOUT(TO)) dutRr (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata[0]), .idone(idone[0]),
        .dreq(dreq), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata[0]), .ddone(ddone[0]), .err(err[0]),
        .AXIStart(axiStart[0]), .DRW(drw[0]), .addressM(addressM[0]),
        .writeDataM(writeDataM[0]), .readDataM(readDataM), .doneM(doneM)
    );

    mem_arbiter #(.RR(0), .TIMEOUT(TO)) dutFixed (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata[1]), .idone(idone[1]),
        .dreq(dreq), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata[1]), .ddone(ddone[1]), .err(err[1]),
        .AXIStart(axiStart[1]), .DRW(drw[1]), .addressM(addressM[1]),
        .writeDataM(writeDataM[1]), .readDataM(readDataM), .doneM(doneM)
    );

    // Compare one observed value against the model's expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive the requester-side inputs
    task automatic applyStimulus(input bit iq, input logic [31:0] ia, input bit dq,
                                 input bit dw, input logic [31:0] da, input logic [31:0] wd);
        ireq   = iq;
        iaddr  = ia;
        dreq   = dq;
        dwrite = dw;
        daddr  = da;
        dwdata = wd;
    endtask

    // Arbitration rule: unit 0 alternates on ties, unit 1 favours data
    function automatic bit pickPort(input int u, input bit iq, input bit dq);
        if (iq && dq) return (u == 0) ? ~lastPort[u] : 1'b1;
        return dq;
    endfunction

    task automatic resetModel();
        for (int u = 0; u < 2; u++) begin
            lastPort[u] = 1'b1;
            modelI[u]   = 32'h0;
            modelD[u]   = 32'h0;
        end
    endtask

    task automatic checkQuiet(input string tag);
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d.%s.start", u, tag), axiStart[u], 1'b0);
            checkOutput($sformatf("u%0d.%s.done", u, tag), {idone[u], ddone[u]}, 2'b00);
            checkOutput($sformatf("u%0d.%s.err", u, tag), err[u], 1'b0);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        doneM = 1'b0;
        readDataM = 32'h0;
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        resetModel();
    endtask

    // One complete transaction, entered and left at the negedge of an IDLE
    // cycle. d = cycles after the start pulse at which doneM is given
    // (negative: never).
    task automatic doTxn(input bit iq, input bit dq, input bit dw,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input int d, input logic [31:0] rd, input bit drop);
        bit          port[2];
        logic [31:0] expAddr[2];
        int          doneAt;
        bit          expErr;
        logic [31:0] expData;
        applyStimulus(iq, ia, dq, dw, da, wd);
        for (int u = 0; u < 2; u++) begin
            port[u]    = pickPort(u, iq, dq);
            expAddr[u] = port[u] ? da : ia;
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d.start", u), axiStart[u], 1'b1);
            checkOutput($sformatf("u%0d.addr", u), addressM[u], expAddr[u]);
            checkOutput($sformatf("u%0d.wdata", u), writeDataM[u], port[u] ? wd : 32'h0);
            checkOutput($sformatf("u%0d.drw", u), drw[u], port[u] ? dw : 1'b0);
            lastPort[u] = port[u];
        end
        if (drop) applyStimulus(0, ia, 0, dw, da, wd);
        expErr  = (d < 0) || (d > TO + 1);
        doneAt  = expErr ? TO + 2 : d + 1;
        expData = expErr ? 32'h0 : rd;
        for (int c = 0; c < doneAt; c++) begin
            doneM     = (c == d);
            readDataM = (c == d) ? rd : $urandom;
            @(negedge clk);
            doneM = 1'b0;
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("u%0d.startPulse", u), axiStart[u], 1'b0);
                if (c + 1 < doneAt)
                    checkOutput($sformatf("u%0d.busy", u), {idone[u], ddone[u]}, 2'b00);
            end
        end
        for (int u = 0; u < 2; u++) begin
            if (port[u]) modelD[u] = expData;
            else         modelI[u] = expData;
            checkOutput($sformatf("u%0d.donePort", u), {idone[u], ddone[u]}, port[u] ? 2'b01 : 2'b10);
            checkOutput($sformatf("u%0d.err", u), err[u], expErr);
            checkOutput($sformatf("u%0d.irdata", u), irdata[u], modelI[u]);
            checkOutput($sformatf("u%0d.drdata", u), drdata[u], modelD[u]);
            checkOutput($sformatf("u%0d.addrHold", u), addressM[u], expAddr[u]);
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d.doneOnce", u), {idone[u], ddone[u]}, 2'b00);
            checkOutput($sformatf("u%0d.errOnce", u), err[u], 1'b0);
            checkOutput($sformatf("u%0d.irdataHold", u), irdata[u], modelI[u]);
            checkOutput($sformatf("u%0d.drdataHold", u), drdata[u], modelD[u]);
        end
    endtask

    // Run-time guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting mem_arbiter bench");
        doReset();

        // Reset values
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d.rst.start", u), axiStart[u], 1'b0);
            checkOutput($sformatf("u%0d.rst.drw", u), drw[u], 1'b0);
            checkOutput($sformatf("u%0d.rst.done", u), {idone[u], ddone[u], err[u]}, 3'b000);
            checkOutput($sformatf("u%0d.rst.addr", u), addressM[u], 32'h0);
            checkOutput($sformatf("u%0d.rst.wdata", u), writeDataM[u], 32'h0);
            checkOutput($sformatf("u%0d.rst.irdata", u), irdata[u], 32'h0);
            checkOutput($sformatf("u%0d.rst.drdata", u), drdata[u], 32'h0);
        end

        // Directed store, then directed fetch
        doTxn(0, 1, 1, 32'h0, 32'h100, 32'hDEADBEEF, 5, $urandom, 1);
        doTxn(1, 0, 0, 32'h40, 32'h0, 32'h0, 2, 32'h00500093, 1);

        // Both ports held from reset: unit 0 alternates I,D,I,D; unit 1 takes D
        doReset();
        for (int k = 0; k < 4; k++)
            doTxn(1, 1, k[0], 32'h1000 + k, 32'h2000 + k, $urandom, k, $urandom, 0);

        // Timeout with doneM never given, then a stray doneM while idle
        doTxn(0, 1, 1, 32'h0, 32'h300, 32'h12345678, -1, 32'h0, 1);
        doneM     = 1'b1;
        readDataM = 32'hCAFEF00D;
        @(negedge clk);
        doneM = 1'b0;
        checkQuiet("strayIdle");
        @(negedge clk);
        checkQuiet("strayIdle2");

        // Reset during WAIT abandons the transaction
        applyStimulus(0, 32'h0, 1, 0, 32'h200, 32'h0);
        @(negedge clk);
        for (int u = 0; u < 2; u++)
            checkOutput($sformatf("u%0d.midStart", u), axiStart[u], 1'b1);
        applyStimulus(0, 32'h0, 0, 0, 32'h200, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        resetModel();
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d.midRst.ctl", u),
                        {axiStart[u], drw[u], idone[u], ddone[u], err[u]}, 5'b00000);
            checkOutput($sformatf("u%0d.midRst.addr", u), addressM[u], 32'h0);
            checkOutput($sformatf("u%0d.midRst.wdata", u), writeDataM[u], 32'h0);
            checkOutput($sformatf("u%0d.midRst.irdata", u), irdata[u], 32'h0);
            checkOutput($sformatf("u%0d.midRst.drdata", u), drdata[u], 32'h0);
        end
        doneM     = 1'b1;
        readDataM = 32'h55AA55AA;
        @(negedge clk);
        doneM = 1'b0;
        checkQuiet("afterRst");
        @(negedge clk);
        checkQuiet("afterRst2");
        doTxn(0, 1, 0, 32'h0, 32'h204, 32'h0, 1, 32'h0BADF00D, 1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit iq, dq;
            int d;
            iq = $urandom_range(0, 1);
            dq = $urandom_range(0, 1);
            if (!iq && !dq) dq = 1'b1;
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO));
            doTxn(iq, dq, $urandom_range(0, 1), $urandom, $urandom, $urandom,
                  d, $urandom, $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
